data_mem_ctrl: RTL and testbench
================================

DATA_MEM_CTRL -- requirements
Module: DATA_MEM_CTRL

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-002 SHALL have parameter REG_WIDTH, default 32, data word width (multiple of 16).
REQ-003 SHALL have parameter DEPTH, default 256, number of words stored.
REQ-004 SHALL have parameter LATENCY, default 1, read response latency in cycles (legal 1..4).
REQ-005 SHALL have ports:
- CLK  in  1  single clock, rising edge.
- RST  in  1  synchronous, active-low reset.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  request accepted when VALID&&READY.
- REQ_WE  in  1  1=store, 0=load.
- REQ_ADDR  in  ADDR_WIDTH  byte address.
- REQ_SIZE  in  2  00 byte, 01 half, 10 word, 11 illegal.
- REQ_UNSIGNED  in  1  load zero-extends when 1, sign-extends when 0.
- REQ_WDATA  in  REG_WIDTH  store data, right-aligned.
- RSP_VALID  out  1  one-cycle response strobe.
- RSP_RDATA  out  REG_WIDTH  load result, extended.
- RSP_ERR  out  1  request rejected.
- BUSY  out  1  memory clearing.
- TEST_VALUE  out  16  bits [15:0] of word 0, combinational.

Function
REQ-006 SHALL implement states CLEAR, IDLE, WAIT; REQ_READY=1 only in IDLE.
REQ-007 CLEAR SHALL zero one word per cycle, index 0..DEPTH-1 via counter, BUSY=1; after writing DEPTH-1 go IDLE (clear takes exactly DEPTH cycles).
REQ-008 Word index SHALL be REQ_ADDR >> log2(REG_WIDTH/8); byte lane from low address bits.
REQ-009 Request SHALL be error when: REQ_SIZE=11; half with addr[0]=1; word with low lane bits nonzero; word index >= DEPTH.
REQ-010 Error request SHALL not modify memory; response RSP_ERR=1, RSP_RDATA=0.
REQ-011 Store SHALL write only selected byte lanes (byte/half merge) at the acceptance edge; other lanes unchanged.
REQ-012 Store response SHALL assert RSP_VALID one cycle after acceptance (T+1), regardless of LATENCY.
REQ-013 Load SHALL sample memory at acceptance cycle T, and RSP_VALID SHALL assert at T+LATENCY with selected lane extended per REQ_UNSIGNED.
REQ-014 After acceptance state SHALL be WAIT until the response cycle; in the response cycle state SHALL be IDLE, allowing back-to-back acceptance at T+1 (store) or T+LATENCY (load).
REQ-015 Only one request SHALL be outstanding; REQ_VALID while not ready SHALL be ignored and not latched.
REQ-016 Load accepted at or after T+1 of a store to same word SHALL return the stored data.
REQ-017 RSP_VALID SHALL be high exactly one cycle per accepted request; RSP_RDATA/RSP_ERR SHALL be 0 when RSP_VALID=0.
REQ-018 TEST_VALUE SHALL reflect memory word 0 combinationally, including during CLEAR.

Reset
REQ-019 RST=0 at a rising edge, in any state, SHALL enter CLEAR with counter=0 next cycle.
REQ-020 Reset SHALL discard any pending response; RSP_VALID=0, RSP_ERR=0, RSP_RDATA=0, REQ_READY=0, BUSY=1 from the cycle after reset sampled.
REQ-021 RST held low SHALL hold counter at 0; clearing completes DEPTH cycles after RST rises.

Verification (DEPTH=16, LATENCY=2, REG_WIDTH=32)
REQ-022 Reset release -> BUSY=1 for 16 cycles, REQ_READY=0; then REQ_READY=1, load addr 0x3C returns 0, TEST_VALUE=0.
REQ-023 Store word 0xDEADBEEF addr 0x0, then load word addr 0x0 -> RSP_VALID at T+1 then T+2 of load, RDATA=0xDEADBEEF, TEST_VALUE=0xBEEF.
REQ-024 Store byte 0x80 addr 0x5, load byte signed addr 0x5 -> 0xFFFFFF80; unsigned -> 0x00000080; load word addr 0x4 -> 0x00008000.
REQ-025 Store word addr 0x2, load half addr 0x3, size 11, word addr 0x40 -> each RSP_ERR=1, RDATA=0, memory unchanged.
REQ-026 Load accepted, RST=0 the next cycle -> no RSP_VALID, CLEAR re-entered, word 0 previously 0xDEADBEEF reads 0 after clear.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Single-port data memory controller: byte/half/word loads and stores with lane merge,
// sign/zero extension, request error detection and a power-up clear sweep.
module data_mem_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int REG_WIDTH  = 32,
    parameter int DEPTH      = 256,
    parameter int LATENCY    = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic                  REQ_WE,
    input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [1:0]            REQ_SIZE,
    input  logic                  REQ_UNSIGNED,
    input  logic [REG_WIDTH-1:0]  REQ_WDATA,
    output logic                  RSP_VALID,
    output logic [REG_WIDTH-1:0]  RSP_RDATA,
    output logic                  RSP_ERR,
    output logic                  BUSY,
    output logic [15:0]           TEST_VALUE
);
    localparam int NB        = REG_WIDTH / 8;
    localparam int LANE_BITS = $clog2(NB);
    localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WAIT_INIT = (LATENCY > 1) ? LATENCY - 2 : 0;

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_WAIT} state_t;

    state_t                 state_q;
    logic [IDX_W-1:0]       clr_cnt_q;
    logic [1:0]             wait_cnt_q;
    logic                   rsp_valid_q;
    logic                   rsp_err_q;
    logic                   rsp_load_q;
    logic                   rsp_uns_q;
    logic [1:0]             rsp_size_q;
    logic [LANE_BITS-1:0]   rsp_lane_q;

    logic [ADDR_WIDTH-1:0]  word_addr;
    logic [LANE_BITS-1:0]   lane;
    logic                   req_err;
    logic                   accept;
    logic                   clearing;
    logic [NB-1:0]          be;
    logic [REG_WIDTH-1:0]   wdata_rep;
    logic                   mem_we;
    logic                   rd_en;
    logic [IDX_W-1:0]       mem_idx;
    logic [NB-1:0]          mem_be;
    logic [REG_WIDTH-1:0]   mem_wdata;
    logic [REG_WIDTH-1:0]   rd_word;
    logic [REG_WIDTH-1:0]   shifted;
    logic [REG_WIDTH-1:0]   load_data;

    assign word_addr = REQ_ADDR >> LANE_BITS;
    assign lane      = REQ_ADDR[LANE_BITS-1:0];
    assign accept    = RST && (state_q == S_IDLE) && REQ_VALID;
    assign clearing  = RST && (state_q == S_CLEAR);

    always_comb begin
        req_err   = 1'b0;
        be        = '1;
        wdata_rep = REQ_WDATA;
        case (REQ_SIZE)
            2'b00: begin
                be        = NB'(1) << lane;
                wdata_rep = {NB{REQ_WDATA[7:0]}};
            end
            2'b01: begin
                req_err   = REQ_ADDR[0];
                be        = NB'(3) << lane;
                wdata_rep = {(NB/2){REQ_WDATA[15:0]}};
            end
            2'b10:   req_err = (lane != '0);
            default: req_err = 1'b1;
        endcase
        if (word_addr >= ADDR_WIDTH'(DEPTH)) begin
            req_err = 1'b1;
        end
    end

    // The clear sweep and accepted stores share the one write port.
    assign mem_we    = clearing || (accept && REQ_WE && !req_err);
    assign rd_en     = accept && !REQ_WE && !req_err;
    assign mem_idx   = clearing ? clr_cnt_q : word_addr[IDX_W-1:0];
    assign mem_be    = clearing ? '1 : be;
    assign mem_wdata = clearing ? '0 : wdata_rep;

    // One byte-wide RAM per lane so partial stores need no read-modify-write.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] rd_byte_q;

            always_ff @(posedge CLK) begin
                if (mem_we && mem_be[gi]) begin
                    lane_mem[mem_idx] <= mem_wdata[gi*8 +: 8];
                end
                if (rd_en) begin
                    rd_byte_q <= lane_mem[mem_idx];
                end
            end

            assign rd_word[gi*8 +: 8] = rd_byte_q;

            if (gi < 2) begin : g_tv
                assign TEST_VALUE[gi*8 +: 8] = lane_mem[0];
            end
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q     <= S_CLEAR;
            clr_cnt_q   <= '0;
            wait_cnt_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_load_q  <= 1'b0;
            rsp_uns_q   <= 1'b0;
            rsp_size_q  <= '0;
            rsp_lane_q  <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_CLEAR: begin
                    if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
                        clr_cnt_q <= '0;
                        state_q   <= S_IDLE;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (REQ_VALID) begin
                        rsp_err_q  <= req_err;
                        rsp_load_q <= !REQ_WE;
                        rsp_uns_q  <= REQ_UNSIGNED;
                        rsp_size_q <= REQ_SIZE;
                        rsp_lane_q <= lane;
                        if (REQ_WE || LATENCY == 1) begin
                            rsp_valid_q <= 1'b1;
                        end else begin
                            wait_cnt_q <= 2'(WAIT_INIT);
                            state_q    <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt_q == '0) begin
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 1'b1;
                    end
                end
                default: state_q <= S_CLEAR;
            endcase
        end
    end

    assign shifted = rd_word >> {rsp_lane_q, 3'b000};

    always_comb begin
        case (rsp_size_q)
            2'b00:   load_data = rsp_uns_q ? {{(REG_WIDTH-8){1'b0}}, shifted[7:0]}
                                           : {{(REG_WIDTH-8){shifted[7]}}, shifted[7:0]};
            2'b01:   load_data = rsp_uns_q ? {{(REG_WIDTH-16){1'b0}}, shifted[15:0]}
                                           : {{(REG_WIDTH-16){shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    assign REQ_READY = (state_q == S_IDLE);
    assign BUSY      = (state_q == S_CLEAR);
    assign RSP_VALID = rsp_valid_q;
    assign RSP_ERR   = rsp_valid_q && rsp_err_q;
    assign RSP_RDATA = (rsp_valid_q && rsp_load_q && !rsp_err_q) ? load_data : '0;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl (DEPTH=16, LATENCY=2, REG_WIDTH=32): stimulus pushes
// expected responses, a negedge monitor pops and compares data, error flag and latency.
module tb_data_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [1:0]  req_size = '0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic [15:0] test_value;

    int vecs = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    data_mem_ctrl #(
        .ADDR_WIDTH(32),
        .REG_WIDTH (32),
        .DEPTH     (16),
        .LATENCY   (2)
    ) dut (
        .CLK         (clk),
        .RST         (rst),
        .REQ_VALID   (req_valid),
        .REQ_READY   (req_ready),
        .REQ_WE      (req_we),
        .REQ_ADDR    (req_addr),
        .REQ_SIZE    (req_size),
        .REQ_UNSIGNED(req_unsigned),
        .REQ_WDATA   (req_wdata),
        .RSP_VALID   (rsp_valid),
        .RSP_RDATA   (rsp_rdata),
        .RSP_ERR     (rsp_err),
        .BUSY        (busy),
        .TEST_VALUE  (test_value)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: one scoreboard pop per response strobe.
    always @(negedge clk) begin
        if (rsp_valid) begin
            vecs++;
            if (sb_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_rsp: cycle %0d rdata=%08h err=%0b, required no response",
                         cyc, rsp_rdata, rsp_err);
            end else begin
                mon_e = sb_q.pop_front();
                if (rsp_rdata !== mon_e.rdata || rsp_err !== mon_e.err || (cyc - mon_e.acc) != mon_e.lat) begin
                    miscompares++;
                    $display("FAIL %s: rdata=%08h err=%0b lat=%0d, required rdata=%08h err=%0b lat=%0d",
                             mon_e.name, rsp_rdata, rsp_err, cyc - mon_e.acc,
                             mon_e.rdata, mon_e.err, mon_e.lat);
                end else begin
                    $display("rsp %-16s rdata=%08h err=%0b lat=%0d", mon_e.name, rsp_rdata, rsp_err,
                             cyc - mon_e.acc);
                end
            end
        end else if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_rsp_zero: cycle %0d rdata=%08h err=%0b, required 0/0", cyc, rsp_rdata, rsp_err);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h, required %08h", name, act, exp);
        end else begin
            $display("chk %-16s = %08h", name, act);
        end
    endtask

    task automatic issue(input string name, input logic we, input logic [31:0] addr,
                         input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err, input bit push);
        exp_t e;
        int guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            vecs++;
            miscompares++;
            $display("FAIL %s_ready_timeout: ready=0 after %0d cycles, required 1", name, guard);
            return;
        end
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.lat   = we ? 1 : 2;
        e.acc   = cyc;
        e.name  = name;
        if (push) sb_q.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (sb_q.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (sb_q.size() != 0) begin
            vecs++;
            miscompares++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb_q.size());
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    // Starting from a negedge with rst just released, count BUSY cycles and check READY stays low.
    task automatic check_clear(input string name);
        int busy_cycles = 0;
        bit ready_seen = 1'b0;
        while (busy && busy_cycles < 100) begin
            if (req_ready) ready_seen = 1'b1;
            busy_cycles++;
            @(negedge clk);
        end
        check({name, "_busy_cycles"}, 32'(busy_cycles), 32'd16);
        check({name, "_ready_in_clr"}, {31'b0, ready_seen}, 32'd0);
        check({name, "_ready_after"}, {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd1);
        check("rst_ready", {31'b0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        rst = 1'b1;
        check_clear("clr1");

        //    name              we    addr      size   uns   wdata          rdata          err
        issue("ld_w_3c",       1'b0, 32'h3C, 2'b10, 1'b0, 32'h0,        32'h0,         1'b0, 1);
        drain();
        check("tv_after_clear", {16'h0, test_value}, 32'h0);

        issue("st_w_0",        1'b1, 32'h0,  2'b10, 1'b0, 32'hDEADBEEF, 32'h0,         1'b0, 1);
        issue("ld_w_0",        1'b0, 32'h0,  2'b10, 1'b0, 32'h0,        32'hDEADBEEF,  1'b0, 1);
        drain();
        check("tv_beef", {16'h0, test_value}, 32'h0000BEEF);

        issue("st_b_5",        1'b1, 32'h5,  2'b00, 1'b0, 32'h00000080, 32'h0,         1'b0, 1);
        issue("ld_b_5_s",      1'b0, 32'h5,  2'b00, 1'b0, 32'h0,        32'hFFFFFF80,  1'b0, 1);
        issue("ld_b_5_u",      1'b0, 32'h5,  2'b00, 1'b1, 32'h0,        32'h00000080,  1'b0, 1);
        issue("ld_w_4",        1'b0, 32'h4,  2'b10, 1'b0, 32'h0,        32'h00008000,  1'b0, 1);

        issue("st_w_2_err",    1'b1, 32'h2,  2'b10, 1'b0, 32'h11111111, 32'h0,         1'b1, 1);
        issue("ld_h_3_err",    1'b0, 32'h3,  2'b01, 1'b0, 32'h0,        32'h0,         1'b1, 1);
        issue("ld_sz11_err",   1'b0, 32'h0,  2'b11, 1'b0, 32'h0,        32'h0,         1'b1, 1);
        issue("ld_w_40_err",   1'b0, 32'h40, 2'b10, 1'b0, 32'h0,        32'h0,         1'b1, 1);
        issue("st_w_40_err",   1'b1, 32'h40, 2'b10, 1'b0, 32'h22222222, 32'h0,         1'b1, 1);
        issue("ld_w_0_keep",   1'b0, 32'h0,  2'b10, 1'b0, 32'h0,        32'hDEADBEEF,  1'b0, 1);

        issue("st_h_6",        1'b1, 32'h6,  2'b01, 1'b0, 32'hA5A51234, 32'h0,         1'b0, 1);
        issue("ld_w_4_merge",  1'b0, 32'h4,  2'b10, 1'b0, 32'h0,        32'h12348000,  1'b0, 1);
        issue("ld_b_7_s",      1'b0, 32'h7,  2'b00, 1'b0, 32'h0,        32'h00000012,  1'b0, 1);
        issue("st_h_2",        1'b1, 32'h2,  2'b01, 1'b0, 32'hFFFF8001, 32'h0,         1'b0, 1);
        issue("ld_h_2_s",      1'b0, 32'h2,  2'b01, 1'b0, 32'h0,        32'hFFFF8001,  1'b0, 1);
        issue("ld_h_2_u",      1'b0, 32'h2,  2'b01, 1'b1, 32'h0,        32'h00008001,  1'b0, 1);
        drain();
        check("tv_still_beef", {16'h0, test_value}, 32'h0000BEEF);

        // A store presented while the controller waits on a load must be dropped.
        issue("ld_w_3c_b",     1'b0, 32'h3C, 2'b10, 1'b0, 32'h0,        32'h0,         1'b0, 1);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'hC;
        req_size  = 2'b10;
        req_wdata = 32'h12345678;
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_we = 1'b0;
        issue("ld_w_c_ignored", 1'b0, 32'hC, 2'b10, 1'b0, 32'h0,       32'h0,         1'b0, 1);
        drain();

        // Reset right after a load is accepted: its response must never appear.
        issue("ld_w_0_abort",  1'b0, 32'h0,  2'b10, 1'b0, 32'h0,        32'h0,         1'b0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst2_busy", {31'b0, busy}, 32'd1);
        check("rst2_ready", {31'b0, req_ready}, 32'd0);
        check("rst2_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        rst = 1'b1;
        check_clear("clr2");
        check("tv_after_clr2", {16'h0, test_value}, 32'h0);
        issue("ld_w_0_cleared", 1'b0, 32'h0, 2'b10, 1'b0, 32'h0,        32'h0,         1'b0, 1);
        issue("ld_w_4_cleared", 1'b0, 32'h4, 2'b10, 1'b0, 32'h0,        32'h0,         1'b0, 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end
endmodule
